// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares the 128-bit line-refill memory port between the Icache and Dcache.
// One-cycle request pulses are latched into pending slots (newest wins),
// granted round-robin from IDLE (same-cycle pulses bypass the slot), and the
// memory request is held until mem_ack_i. Responses return as one-cycle
// ready pulses. ic_flush_i drops a queued Icache request and suppresses an
// in-flight Icache response.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ic_valid_req_i/ic_addr_i   Icache line-read request pulse + address
//   ic_flush_i                 jump flush for Icache traffic
//   ic_ready_o/ic_rdata_o      Icache refill pulse + line
//   dc_valid_req_i/dc_we_i/dc_addr_i/dc_wdata_i  Dcache request pulse
//   dc_ready_o/dc_rdata_o      Dcache completion pulse + refill line
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o    memory request (level)
//   mem_ack_i/mem_rdata_i      memory completion + read line
//   arb_busy_o                 a transaction is outstanding
module cache_mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_valid_req_i,
  input  logic [31:0]  ic_addr_i,
  input  logic         ic_flush_i,
  output logic         ic_ready_o,
  output logic [127:0] ic_rdata_o,
  input  logic         dc_valid_req_i,
  input  logic         dc_we_i,
  input  logic [31:0]  dc_addr_i,
  input  logic [127:0] dc_wdata_i,
  output logic         dc_ready_o,
  output logic [127:0] dc_rdata_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_rdata_i,
  output logic         arb_busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t         r_state;
  logic           r_ic_pend;
  logic [31:0]    r_ic_addr;
  logic           r_dc_pend;
  logic           r_dc_we;
  logic [31:0]    r_dc_addr;
  logic [127:0]   r_dc_wdata;
  logic           r_last_d;   // 1: last completed grant was Dcache
  logic           r_discard;  // in-flight Icache response is stale

  // Candidates: pending slot or same-cycle pulse. A flush kills the queued
  // Icache slot but a pulse in the flush cycle is a fresh request.
  logic           w_ic_cand, w_dc_cand, w_grant_i, w_grant_d;
  logic [31:0]    w_ic_addr, w_dc_addr;
  logic           w_dc_we;
  logic [127:0]   w_dc_wdata;

  assign w_ic_cand  = ic_valid_req_i | (r_ic_pend & ~ic_flush_i);
  assign w_dc_cand  = dc_valid_req_i | r_dc_pend;
  assign w_ic_addr  = ic_valid_req_i ? ic_addr_i  : r_ic_addr;
  assign w_dc_addr  = dc_valid_req_i ? dc_addr_i  : r_dc_addr;
  assign w_dc_we    = dc_valid_req_i ? dc_we_i    : r_dc_we;
  assign w_dc_wdata = dc_valid_req_i ? dc_wdata_i : r_dc_wdata;

  // On a tie, grant the side opposite the last completed grant.
  assign w_grant_i  = (r_state == IDLE) & w_ic_cand & (~w_dc_cand | r_last_d);
  assign w_grant_d  = (r_state == IDLE) & w_dc_cand & ~w_grant_i;

  assign arb_busy_o = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ic_pend   <= 1'b0;
      r_ic_addr   <= '0;
      r_dc_pend   <= 1'b0;
      r_dc_we     <= 1'b0;
      r_dc_addr   <= '0;
      r_dc_wdata  <= '0;
      r_last_d    <= 1'b1;
      r_discard   <= 1'b0;
      ic_ready_o  <= 1'b0;
      ic_rdata_o  <= '0;
      dc_ready_o  <= 1'b0;
      dc_rdata_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      ic_ready_o <= 1'b0;
      dc_ready_o <= 1'b0;

      // Pending slots: a grant consumes the slot (and any bypassed pulse).
      if (w_grant_i)           r_ic_pend <= 1'b0;
      else if (ic_valid_req_i) begin
        r_ic_pend <= 1'b1;
        r_ic_addr <= ic_addr_i;
      end else if (ic_flush_i) r_ic_pend <= 1'b0;

      if (w_grant_d)           r_dc_pend <= 1'b0;
      else if (dc_valid_req_i) begin
        r_dc_pend  <= 1'b1;
        r_dc_we    <= dc_we_i;
        r_dc_addr  <= dc_addr_i;
        r_dc_wdata <= dc_wdata_i;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= w_ic_addr & 32'hFFFF_FFF0;
            mem_wdata_o <= '0;
            r_state     <= BUSY_I;
          end else if (w_grant_d) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= w_dc_we;
            mem_addr_o  <= w_dc_addr & 32'hFFFF_FFF0;
            mem_wdata_o <= w_dc_wdata;
            r_state     <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_discard <= 1'b0;
            // A flush coinciding with the ack also kills this response.
            if (!r_discard && !ic_flush_i) begin
              ic_ready_o <= 1'b1;
              ic_rdata_o <= mem_rdata_i;
            end
          end else if (ic_flush_i) begin
            r_discard <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            r_state    <= IDLE;
            r_last_d   <= 1'b1;
            dc_ready_o <= 1'b1;
            if (!mem_we_o) dc_rdata_o <= mem_rdata_i;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a vector table (inputs applied for
// one cycle, outputs expected just after that cycle's clock edge) plus
// hand-written sequences for flush, overwrite and async reset.
module tb_cache_mem_arbiter;

  logic         clk, rst_n;
  logic         ic_valid_req_i, ic_flush_i, ic_ready_o;
  logic [31:0]  ic_addr_i;
  logic [127:0] ic_rdata_o;
  logic         dc_valid_req_i, dc_we_i, dc_ready_o;
  logic [31:0]  dc_addr_i;
  logic [127:0] dc_wdata_i, dc_rdata_o;
  logic         mem_req_o, mem_we_o, mem_ack_i, arb_busy_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_valid_req_i(ic_valid_req_i), .ic_addr_i(ic_addr_i), .ic_flush_i(ic_flush_i),
    .ic_ready_o(ic_ready_o), .ic_rdata_o(ic_rdata_o),
    .dc_valid_req_i(dc_valid_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_ready_o(dc_ready_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .arb_busy_o(arb_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] DEAD = {4{32'hDEADBEEF}};

  typedef struct {
    logic icq; logic [31:0] ica; logic fl;
    logic dcq; logic dcwe; logic [31:0] dca; logic [127:0] dcwd;
    logic ack; logic [127:0] rd;
    logic e_req; logic e_we; logic [31:0] e_addr; logic [127:0] e_wd;
    logic e_icr; logic e_dcr; logic e_busy; logic [127:0] e_icd; logic [127:0] e_dcd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic icq, input logic [31:0] ica, input logic fl,
                     input logic dcq, input logic dcwe, input logic [31:0] dca,
                     input logic [127:0] dcwd, input logic ack, input logic [127:0] rd,
                     input logic e_req, input logic e_we, input logic [31:0] e_addr,
                     input logic [127:0] e_wd, input logic e_icr, input logic e_dcr,
                     input logic e_busy, input logic [127:0] e_icd, input logic [127:0] e_dcd);
    vec_t v;
    v.icq = icq; v.ica = ica; v.fl = fl; v.dcq = dcq; v.dcwe = dcwe; v.dca = dca;
    v.dcwd = dcwd; v.ack = ack; v.rd = rd; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_icr = e_icr; v.e_dcr = e_dcr;
    v.e_busy = e_busy; v.e_icd = e_icd; v.e_dcd = e_dcd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ic_valid_req_i = 0; ic_addr_i = 0; ic_flush_i = 0;
    dc_valid_req_i = 0; dc_we_i = 0; dc_addr_i = 0; dc_wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  // Idle row shorthand: no inputs, given expected outputs.
  task automatic idle(input logic e_req, input logic e_we, input logic [31:0] e_addr,
                      input logic [127:0] e_wd, input logic e_icr, input logic e_dcr,
                      input logic e_busy, input logic [127:0] e_icd, input logic [127:0] e_dcd);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, e_req, e_we, e_addr, e_wd, e_icr, e_dcr, e_busy, e_icd, e_dcd);
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    #12;
    // Reset state
    chk("rst mem_req", mem_req_o, 0);
    chk("rst busy", arb_busy_o, 0);
    chk("rst ic_ready", ic_ready_o, 0);
    chk("rst dc_ready", dc_ready_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst ic_rdata", ic_rdata_o, 0);
    rst_n = 1;
    tick();

    // Simultaneous pulses from reset: Icache wins, Dcache write follows.
    add(1, 32'h100, 0, 1, 1, 32'h200, DEAD, 0, 0,  1, 0, 32'h100, 0, 0, 0, 1, 0, 0);
    idle(1, 0, 32'h100, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 128'h1111,          0, 0, 0, 0, 1, 0, 0, 128'h1111, 0);
    idle(1, 1, 32'h200, DEAD, 0, 0, 1, 128'h1111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 128'h9999,          0, 0, 0, 0, 0, 1, 0, 128'h1111, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 128'h1111, 0);
    // Icache miss with unaligned address.
    add(1, 32'h1234, 0, 0, 0, 0, 0, 0, 0,          1, 0, 32'h1230, 0, 0, 0, 1, 128'h1111, 0);
    idle(1, 0, 32'h1230, 0, 0, 0, 1, 128'h1111, 0);
    idle(1, 0, 32'h1230, 0, 0, 0, 1, 128'h1111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, A5,                 0, 0, 0, 0, 1, 0, 0, A5, 0);
    idle(0, 0, 0, 0, 0, 0, 0, A5, 0);
    // Flush in flight, then flush coinciding with ack.
    add(1, 32'h700, 0, 0, 0, 0, 0, 0, 0,           1, 0, 32'h700, 0, 0, 0, 1, A5, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0,                  1, 0, 32'h700, 0, 0, 0, 1, A5, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 128'h77,            0, 0, 0, 0, 0, 0, 0, A5, 0);
    idle(0, 0, 0, 0, 0, 0, 0, A5, 0);
    add(1, 32'h800, 0, 0, 0, 0, 0, 0, 0,           1, 0, 32'h800, 0, 0, 0, 1, A5, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 128'h88,            0, 0, 0, 0, 0, 0, 0, A5, 0);
    idle(0, 0, 0, 0, 0, 0, 0, A5, 0);
    // Fairness: last grant was I, both continuously refilled -> D, I, D, I.
    add(1, 32'hA00, 0, 1, 0, 32'h900, 0, 0, 0,     1, 0, 32'h900, 0, 0, 0, 1, A5, 0);
    add(0, 0, 0, 1, 0, 32'h940, 0, 1, 128'h55,      0, 0, 0, 0, 0, 1, 0, A5, 128'h55);
    idle(1, 0, 32'hA00, 0, 0, 0, 1, A5, 128'h55);
    add(1, 32'hA40, 0, 0, 0, 0, 0, 1, 128'h66,      0, 0, 0, 0, 1, 0, 0, 128'h66, 128'h55);
    idle(1, 0, 32'h940, 0, 0, 0, 1, 128'h66, 128'h55);
    add(0, 0, 0, 0, 0, 0, 0, 1, 128'h44,            0, 0, 0, 0, 0, 1, 0, 128'h66, 128'h44);
    idle(1, 0, 32'hA40, 0, 0, 0, 1, 128'h66, 128'h44);
    add(0, 0, 0, 0, 0, 0, 0, 1, 128'h33,            0, 0, 0, 0, 1, 0, 0, 128'h33, 128'h44);
    idle(0, 0, 0, 0, 0, 0, 0, 128'h33, 128'h44);

    foreach (vq[i]) begin
      ic_valid_req_i = vq[i].icq; ic_addr_i = vq[i].ica; ic_flush_i = vq[i].fl;
      dc_valid_req_i = vq[i].dcq; dc_we_i = vq[i].dcwe; dc_addr_i = vq[i].dca;
      dc_wdata_i = vq[i].dcwd; mem_ack_i = vq[i].ack; mem_rdata_i = vq[i].rd;
      tick();
      chk($sformatf("v%0d mem_req", i), mem_req_o, vq[i].e_req);
      if (vq[i].e_req) begin
        chk($sformatf("v%0d mem_we", i), mem_we_o, vq[i].e_we);
        chk($sformatf("v%0d mem_addr", i), mem_addr_o, vq[i].e_addr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, vq[i].e_wd);
      end
      chk($sformatf("v%0d ic_ready", i), ic_ready_o, vq[i].e_icr);
      chk($sformatf("v%0d dc_ready", i), dc_ready_o, vq[i].e_dcr);
      chk($sformatf("v%0d busy", i), arb_busy_o, vq[i].e_busy);
      chk($sformatf("v%0d ic_rdata", i), ic_rdata_o, vq[i].e_icd);
      chk($sformatf("v%0d dc_rdata", i), dc_rdata_o, vq[i].e_dcd);
    end
    clr_in();

    // Flush of a queued Icache request during BUSY_D: never granted.
    dc_valid_req_i = 1; dc_we_i = 1; dc_addr_i = 32'hB00; dc_wdata_i = DEAD;
    tick(); clr_in();
    chk("fq dc granted", {mem_req_o, mem_we_o}, 2'b11);
    ic_valid_req_i = 1; ic_addr_i = 32'h300;
    tick(); clr_in();
    ic_flush_i = 1;
    tick(); clr_in();
    mem_ack_i = 1;
    tick(); clr_in();
    chk("fq dc_ready", dc_ready_o, 1);
    chk("fq dc_rdata held on write", dc_rdata_o, 128'h44);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fq no ic grant", mem_req_o, 0);
    end

    // Flush coinciding with a new pulse: the new request survives.
    dc_valid_req_i = 1; dc_addr_i = 32'hC00;
    tick(); clr_in();
    ic_valid_req_i = 1; ic_addr_i = 32'h300;
    tick(); clr_in();
    ic_valid_req_i = 1; ic_addr_i = 32'h400; ic_flush_i = 1;
    tick(); clr_in();
    mem_ack_i = 1; mem_rdata_i = 128'hC0;
    tick(); clr_in();
    chk("fq2 dc_rdata read", dc_rdata_o, 128'hC0);
    tick();
    chk("fq2 ic grant", {mem_req_o, mem_we_o}, 2'b10);
    chk("fq2 ic addr", mem_addr_o, 32'h400);
    mem_ack_i = 1; mem_rdata_i = 128'h400;
    tick(); clr_in();
    chk("fq2 ic_ready", ic_ready_o, 1);
    chk("fq2 ic_rdata", ic_rdata_o, 128'h400);

    // Overwrite: two Icache pulses during BUSY_D, only the newest issues.
    dc_valid_req_i = 1; dc_addr_i = 32'hD00;
    tick(); clr_in();
    ic_valid_req_i = 1; ic_addr_i = 32'h500;
    tick(); clr_in();
    ic_valid_req_i = 1; ic_addr_i = 32'h600;
    tick(); clr_in();
    mem_ack_i = 1;
    tick(); clr_in();
    tick();
    chk("ow ic addr", mem_addr_o, 32'h600);
    chk("ow mem_req", mem_req_o, 1);
    mem_ack_i = 1;
    tick(); clr_in();
    tick();
    chk("ow no second issue", mem_req_o, 0);
    tick();
    chk("ow no second issue 2", mem_req_o, 0);

    // Async reset mid BUSY_D.
    dc_valid_req_i = 1; dc_addr_i = 32'hE00;
    tick(); clr_in();
    tick();
    chk("ar busy before", arb_busy_o, 1);
    #2 rst_n = 0;
    #1;
    chk("ar mem_req async", mem_req_o, 0);
    chk("ar busy async", arb_busy_o, 0);
    tick(); tick();
    rst_n = 1;
    mem_ack_i = 1;
    tick(); clr_in();
    for (int k = 0; k < 3; k++) begin
      chk("ar no ic_ready", ic_ready_o, 0);
      chk("ar no dc_ready", dc_ready_o, 0);
      chk("ar no mem_req", mem_req_o, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single 128-bit line-refill memory port of the bus controller between the instruction cache and the data cache. Both caches issue one-cycle request pulses, so the arbiter latches each pulse into a pending slot. It grants pending slots round-robin, holds the memory request stable until acknowledged, and returns the line to the owning cache as a one-cycle ready pulse. A flush input discards instruction fetches made stale by a jump, both queued and in flight.

## Interface
- No parameters. Line size fixed at 128 bits; addresses 32 bits, line-aligned (bits [3:0] forced to 0 on the memory side).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ic_valid_req_i  in  1  one-cycle Icache line-read request pulse.
- ic_addr_i  in  32  Icache line address, sampled with ic_valid_req_i.
- ic_flush_i  in  1  jump/flush; drops queued Icache request, suppresses in-flight Icache response.
- ic_ready_o  out  1  one-cycle pulse: ic_rdata_o valid.
- ic_rdata_o  out  128  Icache refill line.
- dc_valid_req_i  in  1  one-cycle Dcache request pulse.
- dc_we_i  in  1  1 = line write-back, 0 = line read; sampled with dc_valid_req_i.
- dc_addr_i  in  32  Dcache line address.
- dc_wdata_i  in  128  write-back line.
- dc_ready_o  out  1  one-cycle pulse: read data valid or write done.
- dc_rdata_o  out  128  Dcache refill line (holds last value on writes).
- mem_req_o  out  1  memory request, level, held until mem_ack_i.
- mem_we_o  out  1  write enable for the current request.
- mem_addr_o  out  32  line address, {addr[31:4],4'b0}.
- mem_wdata_o  out  128  write data.
- mem_ack_i  in  1  one-cycle completion; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  128  read line.
- arb_busy_o  out  1  state != IDLE.

## Operation
- Pending slots:
  - ic_pend (addr) and dc_pend (we, addr, wdata) are set on the request pulse.
  - A new pulse into an already-pending, not-yet-granted slot overwrites it (newest wins).
  - A slot clears when granted.
- States: IDLE, BUSY_I, BUSY_D.
- Granting in IDLE:
  - Candidates are pending slots plus same-cycle request pulses (pulse bypass).
  - If only one candidate: grant it.
  - If both: grant the one opposite last_grant.
  - last_grant resets to D, so Icache wins the first tie.
  - Grant registers mem_req_o=1, mem_we_o, mem_addr_o, mem_wdata_o (0 for Icache) and moves to BUSY_I or BUSY_D.
- Holding: in BUSY_*, mem_* stay constant until mem_ack_i.
- On mem_ack_i in BUSY_I:
  - mem_req_o←0, state←IDLE, last_grant←I.
  - If discard flag is clear: ic_rdata_o←mem_rdata_i, ic_ready_o←1 for one cycle.
  - If discard flag is set: no pulse; discard←0.
- On mem_ack_i in BUSY_D:
  - dc_ready_o pulse; dc_rdata_o←mem_rdata_i on reads only; last_grant←D.
- ic_flush_i:
  - Clears ic_pend.
  - In BUSY_I it sets discard (also when coinciding with mem_ack_i: that response is suppressed).
  - An ic_valid_req_i in the same cycle as flush is kept as a new request and is not flushed.
  - Flush never affects Dcache traffic.
- Requests arriving during BUSY_* are only queued; no grant until back in IDLE.
- Reset values:
  - All outputs 0, state IDLE.
  - Pending slots and discard cleared, last_grant=D.
  - Reset mid-transaction drops mem_req_o immediately; the memory side must abandon the transaction.

## Timing
- Pulse in cycle 0 with arbiter IDLE → mem_req_o=1 in cycle 1.
- mem_ack_i in cycle k → ready pulse and mem_req_o=0 in cycle k+1 → earliest next mem_req_o in cycle k+2 (one idle gap between transactions).
- Ready outputs are exactly one cycle wide; rdata outputs hold until the next response.
- Back-to-back alternating traffic is fair: with both slots continuously refilled, grants strictly alternate I, D, I, D.

## Test plan
- Icache miss: ic pulse addr 0x0000_1234 at cycle 0 → mem_req_o=1, mem_addr_o=0x0000_1230, mem_we_o=0 at cycle 1; ack with data 0xA5..A5 at cycle 4 → ic_ready_o=1 with that data at cycle 5, mem_req_o=0.
- Simultaneous pulses, Icache 0x100 and Dcache write 0x200 with wdata 0xDEAD…, from reset → Icache granted first; after its ack, Dcache is granted at ack+2 with mem_we_o=1, mem_wdata_o=0xDEAD…; dc_ready_o pulses after its ack.
- Flush in flight: Icache granted; ic_flush_i at cycle 2; ack at cycle 3 → no ic_ready_o; state IDLE at cycle 4.
- Flush queued: Dcache busy, Icache pulse 0x300 queued, flush before the Dcache ack → Icache is never granted. Repeat with the flush coinciding with a new pulse 0x400 → 0x400 is granted.
- Overwrite: two Icache pulses (0x500, then 0x600) while BUSY_D → only 0x600 is issued.
- Async reset asserted in BUSY_D → mem_req_o and arb_busy_o go 0 without a clock edge; after release, no ready pulses occur.
